// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared state encoding, BCD limits and nibble helpers for the 7-seg display arbiter
package seg7_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHOW0 = 2'd1,
        S_SHOW1 = 2'd2
    } state_t;

    localparam logic [3:0]  BCD_MAX          = 4'd9;
    localparam logic [15:0] DEFAULT_IDLE_BCD = 16'h0000;

    function automatic logic [15:0] bcd_sanitize(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        for (int i = 0; i < 4; i++) begin
            if (v[i*4 +: 4] > BCD_MAX) begin
                r[i*4 +: 4] = 4'h0;
            end
        end
        return r;
    endfunction

    function automatic logic bcd_invalid(input logic [15:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (v[i*4 +: 4] > BCD_MAX) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

endpackage

// File: rtl/seg7_dwell_timer.sv
// rtl/seg7_dwell_timer.sv - saturating dwell counter; dwell_done once DWELL_CYCLES-1 is reached
module seg7_dwell_timer #(
    parameter int DWELL_CYCLES = 100_000_000,
    parameter int TIMER_W      = 27
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_en,
    output logic o_dwell_done
);

    localparam logic [TIMER_W-1:0] LP_LAST = TIMER_W'(DWELL_CYCLES - 1);

    logic [TIMER_W-1:0] r_count;
    logic               w_done;

    assign w_done = (r_count == LP_LAST);

    // Holding at the last value lets a late competitor switch on the very next edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_en && !w_done) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_dwell_done = w_done;

endmodule

// File: rtl/seg7_display_arbiter.sv
// rtl/seg7_display_arbiter.sv - round-robin dwell-enforcing arbiter sharing a 4-digit 7-seg display
// Optional nibble validation: define SEG7_ARB_BCD_CHECK_EN.
module seg7_display_arbiter
    import seg7_pkg::*;
#(
    parameter int          DWELL_CYCLES = 100_000_000,
    parameter int          TIMER_W      = 27,
    parameter logic [15:0] IDLE_BCD     = DEFAULT_IDLE_BCD
) (
    input  logic        clk_100MHz,
    input  logic        rst_n,
    input  logic [1:0]  req,
    input  logic [15:0] bcd0,
    input  logic [15:0] bcd1,
    output logic [1:0]  gnt,
    output logic [3:0]  ones,
    output logic [3:0]  tens,
    output logic [3:0]  hundreds,
    output logic [3:0]  thousands,
    output logic        bcd_err
);

    state_t      r_state;
    state_t      w_state_next;
    logic        r_last;
    logic [1:0]  r_gnt;
    logic [15:0] r_digits;
    logic        w_dwell_done;
    logic        w_timer_clear;
    logic        w_timer_en;
    logic [15:0] w_raw;
    logic [15:0] w_disp;
    logic        w_err;

    assign w_timer_clear = (w_state_next != r_state);
    assign w_timer_en    = (r_state != S_IDLE);

    seg7_dwell_timer #(
        .DWELL_CYCLES (DWELL_CYCLES),
        .TIMER_W      (TIMER_W)
    ) u_dwell_timer (
        .clk          (clk_100MHz),
        .rst_n        (rst_n),
        .i_clear      (w_timer_clear),
        .i_en         (w_timer_en),
        .o_dwell_done (w_dwell_done)
    );

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                case (req)
                    2'b01:   w_state_next = S_SHOW0;
                    2'b10:   w_state_next = S_SHOW1;
                    2'b11:   w_state_next = r_last ? S_SHOW0 : S_SHOW1;
                    default: w_state_next = S_IDLE;
                endcase
            end
            S_SHOW0: begin
                if (!req[0]) begin
                    w_state_next = req[1] ? S_SHOW1 : S_IDLE;
                end else if (req[1] && w_dwell_done) begin
                    w_state_next = S_SHOW1;
                end
            end
            S_SHOW1: begin
                if (!req[1]) begin
                    w_state_next = req[0] ? S_SHOW0 : S_IDLE;
                end else if (req[0] && w_dwell_done) begin
                    w_state_next = S_SHOW0;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Display source follows the next state so gnt and digits land on the same edge.
    always_comb begin
        w_raw = IDLE_BCD;
        case (w_state_next)
            S_SHOW0: w_raw = bcd0;
            S_SHOW1: w_raw = bcd1;
            default: w_raw = IDLE_BCD;
        endcase
    end

`ifdef SEG7_ARB_BCD_CHECK_EN
    assign w_disp = bcd_sanitize(w_raw);
    assign w_err  = bcd_invalid(w_raw);
`else
    assign w_disp = w_raw;
    assign w_err  = 1'b0;
`endif

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_last   <= 1'b1;
            r_gnt    <= 2'b00;
            r_digits <= IDLE_BCD;
        end else begin
            r_digits <= w_disp;
            case (w_state_next)
                S_SHOW0: begin
                    r_gnt  <= 2'b01;
                    r_last <= 1'b0;
                end
                S_SHOW1: begin
                    r_gnt  <= 2'b10;
                    r_last <= 1'b1;
                end
                default: r_gnt <= 2'b00;
            endcase
        end
    end

`ifdef SEG7_ARB_BCD_CHECK_EN
    logic r_bcd_err;

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_bcd_err <= 1'b0;
        end else begin
            r_bcd_err <= w_err;
        end
    end

    assign bcd_err = r_bcd_err;
`else
    assign bcd_err = w_err;
`endif

    assign gnt       = r_gnt;
    assign thousands = r_digits[15:12];
    assign hundreds  = r_digits[11:8];
    assign tens      = r_digits[7:4];
    assign ones      = r_digits[3:0];

endmodule

// File: tb/tb_seg7_display_arbiter.sv
// tb/tb_seg7_display_arbiter.sv - self-checking bench: directed scenarios plus randomized traffic against a reference model
module tb_seg7_display_arbiter;

    localparam int DW = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req;
    logic [15:0] bcd0;
    logic [15:0] bcd1;
    logic [1:0]  gnt;
    logic [3:0]  ones, tens, hundreds, thousands;
    logic        bcd_err;
    logic [15:0] dig;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    seg7_display_arbiter #(
        .DWELL_CYCLES (DW),
        .TIMER_W      (4),
        .IDLE_BCD     (16'h0000)
    ) dut (
        .clk_100MHz (clk),
        .rst_n      (rst_n),
        .req        (req),
        .bcd0       (bcd0),
        .bcd1       (bcd1),
        .gnt        (gnt),
        .ones       (ones),
        .tens       (tens),
        .hundreds   (hundreds),
        .thousands  (thousands),
        .bcd_err    (bcd_err)
    );

    assign dig = {thousands, hundreds, tens, ones};

    // Reference model: who owns the display, how long it has held it, who was served last.
    int          m_owner;
    int          m_held;
    int          m_last;
    int          m_next;
    logic [1:0]  m_gnt;
    logic [15:0] m_dig;
    logic        m_err;

    function automatic logic [15:0] ref_clean(input logic [15:0] v);
        logic [15:0] r;
        r = v;
`ifdef SEG7_ARB_BCD_CHECK_EN
        for (int i = 0; i < 4; i++) begin
            if (((v >> (4 * i)) & 16'hF) > 16'd9) r = r & ~(16'hF << (4 * i));
        end
`endif
        return r;
    endfunction

    function automatic logic ref_bad(input logic [15:0] v);
        logic b;
        b = 1'b0;
`ifdef SEG7_ARB_BCD_CHECK_EN
        for (int i = 0; i < 4; i++) begin
            if (((v >> (4 * i)) & 16'hF) > 16'd9) b = 1'b1;
        end
`endif
        return b;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner = -1;
            m_held  = 0;
            m_last  = 1;
            m_gnt   = 2'b00;
            m_dig   = 16'h0000;
            m_err   = 1'b0;
        end else begin
            if (m_owner < 0) begin
                if (req == 2'b01)      m_next = 0;
                else if (req == 2'b10) m_next = 1;
                else if (req == 2'b11) m_next = 1 - m_last;
                else                   m_next = -1;
            end else if (!req[m_owner]) begin
                m_next = req[1 - m_owner] ? 1 - m_owner : -1;
            end else if (req[1 - m_owner] && m_held >= DW - 1) begin
                m_next = 1 - m_owner;
            end else begin
                m_next = m_owner;
            end
            m_held  = (m_next == m_owner) ? m_held + 1 : 0;
            m_owner = m_next;
            if (m_next >= 0) m_last = m_next;
            m_gnt = (m_next == 0) ? 2'b01 : (m_next == 1) ? 2'b10 : 2'b00;
            m_dig = (m_next == 0) ? bcd0 : (m_next == 1) ? bcd1 : 16'h0000;
            m_err = ref_bad(m_dig);
            m_dig = ref_clean(m_dig);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 2'b00; bcd0 = 16'h4321; bcd1 = 16'h5678;
        #12;
        rst_n = 1'b1;
        vectors++;
        if (gnt !== 2'b00 || dig !== 16'h0000 || bcd_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state gnt=%b dig=%h err=%b expected 00/0000/0", gnt, dig, bcd_err);
        end
        req = 2'b10;
        tick();
        tick();
        vectors++;
        if (gnt !== 2'b10 || dig !== 16'h5678) begin
            miscompares++;
            $display("FAIL show1_before_reset gnt=%b dig=%h expected 10/5678", gnt, dig);
        end
        #3 rst_n = 1'b0;
        #1;
        vectors++;
        if (gnt !== 2'b00 || dig !== 16'h0000) begin
            miscompares++;
            $display("FAIL async_reset gnt=%b dig=%h expected 00/0000", gnt, dig);
        end
        req = 2'b11;
        #2 rst_n = 1'b1;
        tick();
        vectors++;
        if (gnt !== 2'b01 || dig !== 16'h4321) begin
            miscompares++;
            $display("FAIL first_tie gnt=%b dig=%h expected 01/4321", gnt, dig);
        end
    endtask

    task automatic test_single();
        req = 2'b01; bcd0 = 16'h1234;
        tick();
        vectors++;
        if (gnt !== 2'b01 || thousands !== 4'd1 || hundreds !== 4'd2 || tens !== 4'd3 || ones !== 4'd4) begin
            miscompares++;
            $display("FAIL single_grant gnt=%b dig=%h expected 01/1234", gnt, dig);
        end
        for (int i = 0; i < 50; i++) begin
            tick();
            vectors++;
            if (gnt !== 2'b01 || dig !== 16'h1234 || gnt !== m_gnt || dig !== m_dig) begin
                miscompares++;
                $display("FAIL single_hold cyc=%0d gnt=%b dig=%h expected 01/1234", i, gnt, dig);
            end
        end
    endtask

    task automatic test_contention();
        logic [1:0] exp_g;
        rst_n = 1'b0; req = 2'b00;
        #1 rst_n = 1'b1;
        bcd0 = 16'h1111; bcd1 = 16'h2222; req = 2'b11;
        for (int i = 0; i < 17; i++) begin
            tick();
            exp_g = (i < 8 || i >= 16) ? 2'b01 : 2'b10;
            vectors++;
            if (gnt !== exp_g || dig !== ((exp_g == 2'b01) ? 16'h1111 : 16'h2222)) begin
                miscompares++;
                $display("FAIL contention cyc=%0d gnt=%b dig=%h expected gnt=%b", i, gnt, dig, exp_g);
            end
        end
    endtask

    task automatic test_early_release();
        req = 2'b00;
        tick();
        req = 2'b01; bcd0 = 16'h3333;
        tick(); tick(); tick();
        req = 2'b10; bcd1 = 16'h9876;
        tick();
        vectors++;
        if (gnt !== 2'b10 || dig !== 16'h9876 || gnt !== m_gnt) begin
            miscompares++;
            $display("FAIL early_release gnt=%b dig=%h expected 10/9876", gnt, dig);
        end
    endtask

    task automatic test_idle_late();
        req = 2'b00;
        tick();
        vectors++;
        if (gnt !== 2'b00 || dig !== 16'h0000) begin
            miscompares++;
            $display("FAIL idle gnt=%b dig=%h expected 00/0000", gnt, dig);
        end
        req = 2'b01; bcd0 = 16'h0420; bcd1 = 16'h7531;
        for (int i = 0; i < 20; i++) begin
            tick();
            vectors++;
            if (gnt !== 2'b01 || dig !== 16'h0420) begin
                miscompares++;
                $display("FAIL solo cyc=%0d gnt=%b dig=%h expected 01/0420", i, gnt, dig);
            end
        end
        req = 2'b11;
        tick();
        vectors++;
        if (gnt !== 2'b10 || dig !== 16'h7531) begin
            miscompares++;
            $display("FAIL late_competitor gnt=%b dig=%h expected 10/7531", gnt, dig);
        end
    endtask

    task automatic test_bcd_check();
        req = 2'b01; bcd0 = 16'h12A4;
        tick();
        vectors++;
`ifdef SEG7_ARB_BCD_CHECK_EN
        if (gnt !== 2'b01 || dig !== 16'h1204 || bcd_err !== 1'b1) begin
            miscompares++;
            $display("FAIL bcd_replace dig=%h err=%b expected 1204/1", dig, bcd_err);
        end
`else
        if (gnt !== 2'b01 || tens !== 4'hA || bcd_err !== 1'b0) begin
            miscompares++;
            $display("FAIL bcd_pass dig=%h err=%b expected 12A4/0", dig, bcd_err);
        end
`endif
        bcd0 = 16'h1234;
        tick();
        vectors++;
        if (dig !== 16'h1234 || bcd_err !== 1'b0) begin
            miscompares++;
            $display("FAIL bcd_err_pulse dig=%h err=%b expected 1234/0", dig, bcd_err);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0) req = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) bcd0 = 16'($urandom);
            if ($urandom_range(0, 2) == 0) bcd1 = 16'($urandom);
            tick();
            vectors++;
            if (gnt !== m_gnt || dig !== m_dig || bcd_err !== m_err || gnt === 2'b11) begin
                miscompares++;
                $display("FAIL random cyc=%0d gnt=%b dig=%h err=%b expected gnt=%b dig=%h err=%b",
                         i, gnt, dig, bcd_err, m_gnt, m_dig, m_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_early_release();
        test_idle_late();
        test_bcd_check();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
